// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: decoder state encoding and the 640x480@72 raster constants.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int unsigned H_FP     = 24;
   localparam int unsigned H_PULSE  = 40;
   localparam int unsigned H_BP     = 128;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_TOTAL  = 832;
   localparam int unsigned V_FP     = 9;
   localparam int unsigned V_PULSE  = 3;
   localparam int unsigned V_BP     = 28;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_TOTAL  = 520;

   // hpos restarts two cycles after the raw hsync fall (input flop + fall detect)
   localparam int unsigned H_OFFSET_DEF = H_PULSE + H_BP - 2;
   localparam int unsigned V_OFFSET_DEF = V_PULSE + V_BP;

endpackage

// File: rtl/sync_edge_meter.sv
// Two-flop sync edge detector with a low-phase width counter; width latches on the rising edge.
module sync_edge_meter #(
   parameter int unsigned CW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_sync,
   output logic          o_fall,
   output logic [CW-1:0] o_width
);

   logic          r_d1;
   logic          r_d2;
   logic [CW-1:0] r_low;
   logic [CW-1:0] r_width;
   logic          w_rise;

   assign w_rise  = ~r_d2 & r_d1;
   assign o_fall  = r_d2 & ~r_d1;
   assign o_width = r_width;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1    <= 1'b0;
         r_d2    <= 1'b0;
         r_low   <= '0;
         r_width <= '0;
      end else begin
         r_d1 <= i_sync;
         r_d2 <= r_d1;
         if (w_rise) begin
            r_width <= r_low;
            r_low   <= '0;
         end else if (!r_d1 && (r_low != '1)) begin
            r_low <= r_low + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers raster position from active-low hsync/vsync, measures line/frame timing and
// locks once LOCK_FRAMES consecutive frames repeat with stable line length and height.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int unsigned CW          = 10,
   parameter int unsigned H_OFFSET    = H_OFFSET_DEF,
   parameter int unsigned V_OFFSET    = V_OFFSET_DEF,
   parameter int unsigned ACTIVE_W    = H_ACTIVE,
   parameter int unsigned ACTIVE_H    = V_ACTIVE,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic          px_clk,
   input  logic          reset_n,
   input  logic          hsync,
   input  logic          vsync,
   output logic [CW-1:0] x_px,
   output logic [CW-1:0] y_px,
   output logic          activevideo,
   output logic          locked,
   output logic          lock_lost,
   output logic [CW-1:0] line_len,
   output logic [CW-1:0] hsync_width,
   output logic [CW-1:0] frame_lines
);

   localparam logic [CW-1:0] LP_MAX  = '1;
   localparam logic [CW-1:0] LP_HOFF = CW'(H_OFFSET);
   localparam logic [CW-1:0] LP_HEND = CW'(H_OFFSET + ACTIVE_W);
   localparam logic [CW-1:0] LP_VOFF = CW'(V_OFFSET);
   localparam logic [CW-1:0] LP_VEND = CW'(V_OFFSET + ACTIVE_H);
   localparam logic [CW-1:0] LP_LOCK = CW'(LOCK_FRAMES);

   logic          w_h_fall;
   logic [CW-1:0] w_hs_width;
   logic          r_vs_d1, r_vs_d2, w_v_fall;
   logic [CW-1:0] r_hpos, r_vpos, r_line_len, r_frame_lines;
   logic [CW-1:0] r_match_cnt, w_match_nxt;
   logic          r_v_pend, r_ll_valid, r_fl_valid, r_frame_ok, w_ok_nxt;
   state_t        r_state, w_state_nxt;
   logic          w_hpos_sat, w_vpos_sat, w_frame_start, w_line_mm;
   logic          w_fl_same, w_ok_now, w_clr_valid;
   logic [CW-1:0] w_ll_new, w_fl_new;
   logic [CW-1:0] r_x, r_y;
   logic          r_av, r_lock_lost;

   sync_edge_meter #(.CW(CW)) u_hs_meter (
      .clk     (px_clk),
      .rst_n   (reset_n),
      .i_sync  (hsync),
      .o_fall  (w_h_fall),
      .o_width (w_hs_width)
   );

   assign w_v_fall      = r_vs_d2 & ~r_vs_d1;
   assign w_hpos_sat    = (r_hpos == LP_MAX);
   assign w_vpos_sat    = (r_vpos == LP_MAX);
   assign w_frame_start = w_h_fall & (r_v_pend | w_v_fall);
   assign w_ll_new      = r_hpos + 1'b1;
   assign w_fl_new      = r_vpos + 1'b1;
   assign w_line_mm     = w_h_fall & r_ll_valid & (w_ll_new != r_line_len);
   assign w_fl_same     = (w_fl_new == r_frame_lines);
   assign w_ok_now      = r_frame_ok & ~w_line_mm;
   assign w_clr_valid   = (w_state_nxt != r_state) && (w_state_nxt != LOCKED);

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = r_match_cnt;
      w_ok_nxt    = r_frame_ok;
      case (r_state)
         SEARCH: begin
            if (!w_hpos_sat && w_frame_start) begin
               w_state_nxt = TRAIN;
               w_match_nxt = '0;
               w_ok_nxt    = 1'b1;
            end
         end
         TRAIN: begin
            if (w_hpos_sat) begin
               w_state_nxt = SEARCH;
            end else begin
               if (w_line_mm) w_ok_nxt = 1'b0;
               // a mismatching line in the closing frame still disqualifies it
               if (w_frame_start) begin
                  if (r_fl_valid && w_ok_now && w_fl_same) w_match_nxt = r_match_cnt + 1'b1;
                  else                                      w_match_nxt = '0;
                  w_ok_nxt = 1'b1;
                  if (w_match_nxt == LP_LOCK) w_state_nxt = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (w_hpos_sat || w_vpos_sat || w_line_mm ||
                (w_frame_start && r_fl_valid && !w_fl_same))
               w_state_nxt = SEARCH;
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vs_d1       <= 1'b0;
         r_vs_d2       <= 1'b0;
         r_hpos        <= '0;
         r_vpos        <= '0;
         r_v_pend      <= 1'b0;
         r_line_len    <= '0;
         r_frame_lines <= '0;
         r_ll_valid    <= 1'b0;
         r_fl_valid    <= 1'b0;
         r_state       <= SEARCH;
         r_match_cnt   <= '0;
         r_frame_ok    <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_av          <= 1'b0;
         r_lock_lost   <= 1'b0;
      end else begin
         r_vs_d1 <= vsync;
         r_vs_d2 <= r_vs_d1;

         if (w_h_fall)         r_hpos <= '0;
         else if (!w_hpos_sat) r_hpos <= r_hpos + 1'b1;

         if (w_frame_start) begin
            r_vpos        <= '0;
            r_v_pend      <= 1'b0;
            r_frame_lines <= w_fl_new;
         end else begin
            if (w_v_fall) r_v_pend <= 1'b1;
            if (w_h_fall && !w_vpos_sat) r_vpos <= r_vpos + 1'b1;
         end

         if (w_h_fall) r_line_len <= w_ll_new;

         if (w_clr_valid) begin
            r_ll_valid <= 1'b0;
            r_fl_valid <= 1'b0;
         end else begin
            if (w_h_fall)      r_ll_valid <= 1'b1;
            if (w_frame_start) r_fl_valid <= 1'b1;
         end

         r_state     <= w_state_nxt;
         r_match_cnt <= w_match_nxt;
         r_frame_ok  <= w_ok_nxt;

         r_x         <= r_hpos - LP_HOFF;
         r_y         <= r_vpos - LP_VOFF;
         r_av        <= (r_state == LOCKED) &&
                        (r_hpos >= LP_HOFF) && (r_hpos < LP_HEND) &&
                        (r_vpos >= LP_VOFF) && (r_vpos < LP_VEND);
         r_lock_lost <= (r_state == LOCKED) && (w_state_nxt == SEARCH);
      end
   end

   assign x_px        = r_x;
   assign y_px        = r_y;
   assign activevideo = r_av;
   assign locked      = (r_state == LOCKED);
   assign lock_lost   = r_lock_lost;
   assign line_len    = r_line_len;
   assign hsync_width = w_hs_width;
   assign frame_lines = r_frame_lines;

endmodule
